// File: rtl/ex_stage.sv
// MIPS R2000 execute stage: single-cycle ALU, iterative MULT/DIV into HI/LO,
// and the registered EX/MEM bundle.
module ex_stage #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       wb_EX,
  input  logic [2:0]       m_EX,
  input  logic [3:0]       alu_op,
  input  logic             alu_src,
  input  logic             reg_dst,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] read_data1,
  input  logic [WIDTH-1:0] read_data2,
  input  logic [WIDTH-1:0] imm_ext,
  input  logic [4:0]       shamt,
  input  logic [4:0]       rt,
  input  logic [4:0]       rd,
  output logic [1:0]       wb_MEM,
  output logic [2:0]       m,
  output logic             zero,
  output logic [WIDTH-1:0] address_MEM,
  output logic [WIDTH-1:0] write_data_mem,
  output logic [4:0]       write_register_ex,
  output logic             stall,
  output logic             md_busy
);

  localparam int unsigned CW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;

  localparam logic [3:0] MdNone  = 4'd0;
  localparam logic [3:0] MdMult  = 4'd1;
  localparam logic [3:0] MdMultu = 4'd2;
  localparam logic [3:0] MdDiv   = 4'd3;
  localparam logic [3:0] MdDivu  = 4'd4;
  localparam logic [3:0] MdMfhi  = 4'd5;
  localparam logic [3:0] MdMflo  = 4'd6;
  localparam logic [3:0] MdMthi  = 4'd7;
  localparam logic [3:0] MdMtlo  = 4'd8;

  typedef enum logic {StIdle, StRun} md_state_e;

  md_state_e          state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d, neg_q, neg_d, neg_rem_q, neg_rem_d, div0_q, div0_d;

  logic [1:0]         wb_q, wb_d;
  logic [2:0]         m_q, m_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [4:0]         wreg_q, wreg_d;

  logic [WIDTH-1:0]   op_b, alu_res, res_mux;

  assign op_b    = alu_src ? imm_ext : read_data2;
  assign md_busy = (state_q == StRun);
  assign stall   = md_busy & (md_op != MdNone);

  always_comb begin
    alu_res = '0;
    case (alu_op)
      4'd0:    alu_res = read_data1 + op_b;
      4'd1:    alu_res = read_data1 - op_b;
      4'd2:    alu_res = read_data1 & op_b;
      4'd3:    alu_res = read_data1 | op_b;
      4'd4:    alu_res = read_data1 ^ op_b;
      4'd5:    alu_res = ~(read_data1 | op_b);
      4'd6:    alu_res = {{(WIDTH-1){1'b0}}, $signed(read_data1) < $signed(op_b)};
      4'd7:    alu_res = {{(WIDTH-1){1'b0}}, read_data1 < op_b};
      4'd8:    alu_res = op_b << shamt;
      4'd9:    alu_res = op_b >> shamt;
      4'd10:   alu_res = $signed(op_b) >>> shamt;
      4'd11:   alu_res = {op_b[WIDTH-17:0], 16'h0};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    res_mux = alu_res;
    if (md_op == MdMfhi) res_mux = hi_q;
    else if (md_op == MdMflo) res_mux = lo_q;
  end

  // A stalled instruction leaves a bubble behind it in EX/MEM.
  always_comb begin
    wb_d    = '0;
    m_d     = '0;
    zero_d  = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    wreg_d  = '0;
    if (!stall) begin
      wb_d    = wb_EX;
      m_d     = m_EX;
      zero_d  = (res_mux == '0);
      addr_d  = res_mux;
      wdata_d = read_data2;
      wreg_d  = reg_dst ? rd : rt;
    end
  end

  // One iteration: shift-add multiply or restoring divide on magnitudes.
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH-1:0]   div_rem;
  logic               div_ge;
  logic [2*WIDTH-1:0] iter_next, mul_res;
  logic [WIDTH-1:0]   fin_hi, fin_lo, quo, rem;

  always_comb begin
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, mcand_q});
    // When div_ge holds the true difference is below the divisor, so WIDTH bits suffice.
    div_rem   = div_ge ? (div_shift[WIDTH-1:0] - mcand_q) : div_shift[WIDTH-1:0];
    iter_next = is_div_q ? {div_rem, prod_q[WIDTH-2:0], div_ge}
                         : {mul_sum, prod_q[WIDTH-1:1]};
    mul_res   = neg_q ? (~iter_next + 1'b1) : iter_next;
    quo       = iter_next[WIDTH-1:0];
    rem       = iter_next[2*WIDTH-1:WIDTH];
    if (!is_div_q) begin
      fin_hi = mul_res[2*WIDTH-1:WIDTH];
      fin_lo = mul_res[WIDTH-1:0];
    end else if (div0_q) begin
      fin_hi = op_a_q;
      fin_lo = '1;
    end else begin
      fin_hi = neg_rem_q ? (~rem + 1'b1) : rem;
      fin_lo = neg_q ? (~quo + 1'b1) : quo;
    end
  end

  logic             is_start, is_signed;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign is_start  = (md_op == MdMult) | (md_op == MdMultu) | (md_op == MdDiv) |
                     (md_op == MdDivu);
  assign is_signed = (md_op == MdMult) | (md_op == MdDiv);
  assign abs_a     = (is_signed & read_data1[WIDTH-1]) ? (~read_data1 + 1'b1) : read_data1;
  assign abs_b     = (is_signed & read_data2[WIDTH-1]) ? (~read_data2 + 1'b1) : read_data2;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    prod_d    = prod_q;
    mcand_d   = mcand_q;
    op_a_d    = op_a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    case (state_q)
      StIdle: begin
        if (md_op == MdMthi) hi_d = read_data1;
        if (md_op == MdMtlo) lo_d = read_data1;
        if (is_start) begin
          state_d   = StRun;
          count_d   = '0;
          is_div_d  = (md_op == MdDiv) | (md_op == MdDivu);
          neg_d     = is_signed & (read_data1[WIDTH-1] ^ read_data2[WIDTH-1]);
          neg_rem_d = is_signed & read_data1[WIDTH-1];
          div0_d    = (read_data2 == '0);
          op_a_d    = read_data1;
          if (is_div_d) begin
            prod_d  = {{WIDTH{1'b0}}, abs_a};
            mcand_d = abs_b;
          end else begin
            prod_d  = {{WIDTH{1'b0}}, abs_b};
            mcand_d = abs_a;
          end
        end
      end
      StRun: begin
        prod_d  = iter_next;
        count_d = count_q + 1'b1;
        if (count_q == CW'(MD_CYCLES - 1)) begin
          state_d = StIdle;
          count_d = '0;
          hi_d    = fin_hi;
          lo_d    = fin_lo;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      prod_q    <= '0;
      mcand_q   <= '0;
      op_a_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      wb_q      <= '0;
      m_q       <= '0;
      zero_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wreg_q    <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      prod_q    <= prod_d;
      mcand_q   <= mcand_d;
      op_a_q    <= op_a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      wb_q      <= wb_d;
      m_q       <= m_d;
      zero_q    <= zero_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wreg_q    <= wreg_d;
    end
  end

  assign wb_MEM            = wb_q;
  assign m                 = m_q;
  assign zero              = zero_q;
  assign address_MEM       = addr_q;
  assign write_data_mem    = wdata_q;
  assign write_register_ex = wreg_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: driver queues expected EX/MEM bundles, a
// negedge monitor pops one whenever wb_MEM is non-zero.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wb_EX;
  logic [2:0]  m_EX;
  logic [3:0]  alu_op;
  logic        alu_src, reg_dst;
  logic [3:0]  md_op;
  logic [31:0] read_data1, read_data2, imm_ext;
  logic [4:0]  shamt, rt, rd;
  logic [1:0]  wb_MEM;
  logic [2:0]  m;
  logic        zero;
  logic [31:0] address_MEM, write_data_mem;
  logic [4:0]  write_register_ex;
  logic        stall, md_busy;

  always #5 clk = ~clk;

  ex_stage #(.WIDTH(32), .MD_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .wb_EX(wb_EX), .m_EX(m_EX), .alu_op(alu_op),
    .alu_src(alu_src), .reg_dst(reg_dst), .md_op(md_op), .read_data1(read_data1),
    .read_data2(read_data2), .imm_ext(imm_ext), .shamt(shamt), .rt(rt), .rd(rd),
    .wb_MEM(wb_MEM), .m(m), .zero(zero), .address_MEM(address_MEM),
    .write_data_mem(write_data_mem), .write_register_ex(write_register_ex),
    .stall(stall), .md_busy(md_busy)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [74:0] exp_q[$];
  string       name_q[$];

  function automatic logic [74:0] out_vec();
    return {wb_MEM, m, zero, address_MEM, write_data_mem, write_register_ex};
  endfunction

  always @(negedge clk) begin
    if (!rst && wb_MEM != 2'b00) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: got addr=%h wb=%0d", address_MEM, wb_MEM);
      end else begin
        logic [74:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (out_vec() !== e)
          begin
            miscompares++;
            $display("FAIL %s: got %h want %h", n, out_vec(), e);
          end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", n, got, want);
    end
  endtask

  task automatic nop();
    wb_EX = 2'b00; m_EX = 3'b000; alu_op = 4'd0; alu_src = 1'b0; reg_dst = 1'b0;
    md_op = 4'd0; read_data1 = '0; read_data2 = '0; imm_ext = '0; shamt = '0;
    rt = '0; rd = '0;
  endtask

  // Drive one instruction, hold it through any stall, return #1 after its accept edge.
  task automatic issue(input string n, input logic [1:0] wb, input logic [3:0] aop,
                       input logic asrc, input logic rdst, input logic [3:0] mop,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic [4:0] sh, input logic [4:0] t, input logic [4:0] d,
                       input logic [31:0] exp_addr, input int exp_stalls);
    int stalls = 0;
    wb_EX = wb; m_EX = (wb != 2'b00) ? 3'b101 : 3'b000; alu_op = aop; alu_src = asrc;
    reg_dst = rdst; md_op = mop; read_data1 = a; read_data2 = b; imm_ext = imm;
    shamt = sh; rt = t; rd = d;
    if (wb != 2'b00) begin
      exp_q.push_back({wb, m_EX, exp_addr == 32'd0, exp_addr, b, rdst ? d : t});
      name_q.push_back(n);
    end
    @(negedge clk);
    while (stall && stalls < 100) begin
      stalls++;
      @(posedge clk);
      #1;
      vectors++;
      if (out_vec() !== 75'd0) begin
        miscompares++;
        $display("FAIL %s_bubble: got %h want 0", n, out_vec());
      end
      @(negedge clk);
    end
    chk({n, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    @(posedge clk);
    #1;
    nop();
  endtask

  localparam logic [3:0] ADD = 0, SUB = 1, AND_ = 2, OR_ = 3, XOR_ = 4, NOR_ = 5;
  localparam logic [3:0] SLT = 6, SLTU = 7, SLL = 8, SRL = 9, SRA = 10, LUI = 11;
  localparam logic [3:0] NONE = 0, MULT = 1, MULTU = 2, DIV = 3, DIVU = 4;
  localparam logic [3:0] MFHI = 5, MFLO = 6, MTHI = 7;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nop();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {31'd0, out_vec() != 75'd0}, 32'd0);
    chk("reset_busy", {31'd0, md_busy}, 32'd0);
    rst = 1'b0;

    // ALU
    issue("add", 2'd1, ADD, 0, 1, NONE, 32'd7, 32'd5, 0, 0, 5'd2, 5'd3, 32'd12, 0);
    issue("sub_zero", 2'd2, SUB, 0, 0, NONE, 32'd5, 32'd5, 0, 0, 5'd4, 5'd9, 32'd0, 0);
    issue("slt", 2'd1, SLT, 0, 1, NONE, 32'hFFFF_FFFF, 32'd1, 0, 0, 5'd1, 5'd5, 32'd1, 0);
    issue("sltu", 2'd1, SLTU, 0, 1, NONE, 32'hFFFF_FFFF, 32'd1, 0, 0, 5'd1, 5'd6, 32'd0, 0);
    issue("sra", 2'd3, SRA, 0, 1, NONE, 32'd0, 32'h8000_0000, 0, 5'd4, 5'd1, 5'd7,
          32'hF800_0000, 0);
    issue("srl", 2'd1, SRL, 0, 1, NONE, 32'd0, 32'h8000_0000, 0, 5'd4, 5'd1, 5'd8,
          32'h0800_0000, 0);
    issue("sll", 2'd1, SLL, 0, 1, NONE, 32'd0, 32'd1, 0, 5'd31, 5'd1, 5'd10,
          32'h8000_0000, 0);
    issue("and", 2'd1, AND_, 0, 1, NONE, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 0, 5'd1, 5'd11,
          32'h00F0_1234, 0);
    issue("ori", 2'd1, OR_, 1, 0, NONE, 32'hF000_0000, 32'h1111, 32'hFF, 0, 5'd12, 5'd1,
          32'hF000_00FF, 0);
    issue("xor", 2'd1, XOR_, 0, 1, NONE, 32'hFFFF_0000, 32'h0F0F_0F0F, 0, 0, 5'd1, 5'd13,
          32'hF0F0_0F0F, 0);
    issue("nor", 2'd1, NOR_, 0, 1, NONE, 32'd0, 32'd0, 0, 0, 5'd1, 5'd14, 32'hFFFF_FFFF, 0);
    issue("lui", 2'd1, LUI, 1, 0, NONE, 32'd0, 32'd0, 32'h1234, 0, 5'd15, 5'd1,
          32'h1234_0000, 0);
    issue("add_wrap", 2'd1, ADD, 0, 1, NONE, 32'hFFFF_FFFF, 32'd1, 0, 0, 5'd1, 5'd16, 32'd0, 0);

    // MULT -3 x 7 = -21
    issue("mult", 2'd0, ADD, 0, 0, MULT, 32'hFFFF_FFFD, 32'd7, 0, 0, 0, 0, 0, 0);
    issue("mflo_mult", 2'd1, ADD, 0, 1, MFLO, 0, 0, 0, 0, 5'd1, 5'd2, 32'hFFFF_FFEB, 32);
    issue("mfhi_mult", 2'd1, ADD, 0, 1, MFHI, 0, 0, 0, 0, 5'd1, 5'd3, 32'hFFFF_FFFF, 0);

    // Divide by zero, signed divide, overflow case
    issue("divu0", 2'd0, ADD, 0, 0, DIVU, 32'd100, 32'd0, 0, 0, 0, 0, 0, 0);
    issue("mfhi_divu0", 2'd1, ADD, 0, 1, MFHI, 0, 0, 0, 0, 5'd1, 5'd4, 32'd100, 32);
    issue("mflo_divu0", 2'd1, ADD, 0, 1, MFLO, 0, 0, 0, 0, 5'd1, 5'd5, 32'hFFFF_FFFF, 0);
    issue("div", 2'd0, ADD, 0, 0, DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0, 0, 0);
    issue("mflo_div", 2'd1, ADD, 0, 1, MFLO, 0, 0, 0, 0, 5'd1, 5'd6, 32'hFFFF_FFFD, 32);
    issue("mfhi_div", 2'd1, ADD, 0, 1, MFHI, 0, 0, 0, 0, 5'd1, 5'd7, 32'hFFFF_FFFF, 0);
    issue("div_ovf", 2'd0, ADD, 0, 0, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
    issue("mflo_ovf", 2'd1, ADD, 0, 1, MFLO, 0, 0, 0, 0, 5'd1, 5'd8, 32'h8000_0000, 32);
    issue("mfhi_ovf", 2'd1, ADD, 0, 1, MFHI, 0, 0, 0, 0, 5'd1, 5'd9, 32'd0, 0);

    issue("mthi", 2'd0, ADD, 0, 0, MTHI, 32'h55, 0, 0, 0, 0, 0, 0, 0);
    issue("mfhi_mthi", 2'd1, ADD, 0, 1, MFHI, 0, 0, 0, 0, 5'd1, 5'd10, 32'h55, 0);

    // Overlap: ALU op runs under a busy unit; second MULTU waits for it.
    issue("mult_ov", 2'd0, ADD, 0, 0, MULT, 32'd3, 32'd4, 0, 0, 0, 0, 0, 0);
    issue("add_ov", 2'd1, ADD, 0, 1, NONE, 32'd20, 32'd22, 0, 0, 5'd1, 5'd17, 32'd42, 0);
    chk("busy_overlap", {31'd0, md_busy}, 32'd1);
    issue("multu2", 2'd0, ADD, 0, 0, MULTU, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, 0, 0, 31);
    issue("mflo_multu", 2'd1, ADD, 0, 1, MFLO, 0, 0, 0, 0, 5'd1, 5'd18, 32'hFFFF_FFFE, 32);
    issue("mfhi_multu", 2'd1, ADD, 0, 1, MFHI, 0, 0, 0, 0, 5'd1, 5'd19, 32'd1, 0);

    // Reset mid-DIV at count 10
    issue("div_rst", 2'd0, ADD, 0, 0, DIV, 32'd1000, 32'd7, 0, 0, 0, 0, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("busy_before_rst", {31'd0, md_busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_outputs", {31'd0, out_vec() != 75'd0}, 32'd0);
    rst = 1'b0;
    issue("mflo_after_rst", 2'd1, ADD, 0, 1, MFLO, 0, 0, 0, 0, 5'd1, 5'd20, 32'd0, 0);
    issue("mfhi_after_rst", 2'd1, ADD, 0, 1, MFHI, 0, 0, 0, 0, 5'd1, 5'd21, 32'd0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
